// File: rtl/adder_station_pipe.sv
// In-order DEPTH-entry vector add/sub station feeding one shared LATENCY-stage LANES-wide adder.
// Define ADDER_STATION_SATURATE_EN for signed saturating lanes; default is modular arithmetic.
module adder_station_pipe #(
  parameter int unsigned LANES   = 3,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DST_W   = 8,
  parameter int unsigned ID_W    = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [ID_W-1:0]        iId,
  input  logic                   iIssueValid,
  output logic                   oIssueReady,
  input  logic                   iIssueSub,
  input  logic [LANES*WIDTH-1:0] iIssueA,
  input  logic [LANES*WIDTH-1:0] iIssueB,
  input  logic [DST_W-1:0]       iIssueDst,
  input  logic [LANES-1:0]       iIssueWE,
  output logic                   oCommitRequest,
  input  logic                   iCommitGranted,
  output logic [ID_W-1:0]        oCommitId,
  output logic [DST_W-1:0]       oCommitDst,
  output logic [LANES-1:0]       oCommitWE,
  output logic [LANES*WIDTH-1:0] oCommitData,
  output logic                   oBusy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned VecW = LANES * WIDTH;

  typedef enum logic [1:0] {StFree, StWait, StExec, StDone} ent_state_e;

  ent_state_e       state_q [DEPTH];
  logic             sub_q   [DEPTH];
  logic [VecW-1:0]  a_q     [DEPTH];
  logic [VecW-1:0]  b_q     [DEPTH];
  logic [VecW-1:0]  res_q   [DEPTH];
  logic [DST_W-1:0] dst_q   [DEPTH];
  logic [LANES-1:0] we_q    [DEPTH];

  logic [PtrW-1:0]  alloc_q, disp_q, cmt_q;
  logic [CntW-1:0]  count_q, count_d;

  logic             pv_q    [LATENCY];
  logic [PtrW-1:0]  pidx_q  [LATENCY];
  logic [VecW-1:0]  pdata_q [LATENCY];
`ifdef ADDER_STATION_SATURATE_EN
  logic [LANES-1:0] ppos_q  [LATENCY];
  logic [LANES-1:0] pneg_q  [LATENCY];
  logic [LANES-1:0] pos_ovf, neg_ovf;
`endif

  logic             issue_fire, disp_fire, commit_fire;
  logic [VecW-1:0]  sum_vec, wb_data;
  logic [WIDTH-1:0] lane_a, lane_b, lane_r;

  assign oIssueReady    = (count_q != CntW'(DEPTH));
  assign oBusy          = (count_q != '0);
  assign oCommitRequest = (state_q[cmt_q] == StDone);
  assign oCommitId      = iId;
  assign oCommitDst     = oCommitRequest ? dst_q[cmt_q] : '0;
  assign oCommitWE      = oCommitRequest ? we_q[cmt_q]  : '0;
  assign oCommitData    = oCommitRequest ? res_q[cmt_q] : '0;

  assign issue_fire  = iIssueValid && oIssueReady;
  assign disp_fire   = (state_q[disp_q] == StWait);
  assign commit_fire = oCommitRequest && iCommitGranted;

  always_comb begin
    count_d = count_q;
    if (issue_fire && !commit_fire) begin
      count_d = count_q + CntW'(1);
    end else if (!issue_fire && commit_fire) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Subtraction is A + ~B + 1; the carry-in is per lane so lanes never interact.
  always_comb begin
    sum_vec = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_r  = '0;
`ifdef ADDER_STATION_SATURATE_EN
    pos_ovf = '0;
    neg_ovf = '0;
`endif
    for (int l = 0; l < int'(LANES); l++) begin
      lane_a = a_q[disp_q][l*WIDTH +: WIDTH];
      lane_b = sub_q[disp_q] ? ~b_q[disp_q][l*WIDTH +: WIDTH] : b_q[disp_q][l*WIDTH +: WIDTH];
      lane_r = lane_a + lane_b + WIDTH'(sub_q[disp_q]);
      sum_vec[l*WIDTH +: WIDTH] = lane_r;
`ifdef ADDER_STATION_SATURATE_EN
      pos_ovf[l] = !lane_a[WIDTH-1] && !lane_b[WIDTH-1] &&  lane_r[WIDTH-1];
      neg_ovf[l] =  lane_a[WIDTH-1] &&  lane_b[WIDTH-1] && !lane_r[WIDTH-1];
`endif
    end
  end

  always_comb begin
    wb_data = pdata_q[LATENCY-1];
`ifdef ADDER_STATION_SATURATE_EN
    for (int l = 0; l < int'(LANES); l++) begin
      if (ppos_q[LATENCY-1][l]) begin
        wb_data[l*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (pneg_q[LATENCY-1][l]) begin
        wb_data[l*WIDTH +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      alloc_q <= '0;
      disp_q  <= '0;
      cmt_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        state_q[i] <= StFree;
        sub_q[i]   <= 1'b0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        res_q[i]   <= '0;
        dst_q[i]   <= '0;
        we_q[i]    <= '0;
      end
      for (int s = 0; s < int'(LATENCY); s++) begin
        pv_q[s]    <= 1'b0;
        pidx_q[s]  <= '0;
        pdata_q[s] <= '0;
`ifdef ADDER_STATION_SATURATE_EN
        ppos_q[s]  <= '0;
        pneg_q[s]  <= '0;
`endif
      end
    end else begin
      if (issue_fire) begin
        state_q[alloc_q] <= StWait;
        sub_q[alloc_q]   <= iIssueSub;
        a_q[alloc_q]     <= iIssueA;
        b_q[alloc_q]     <= iIssueB;
        dst_q[alloc_q]   <= iIssueDst;
        we_q[alloc_q]    <= iIssueWE;
        alloc_q          <= alloc_q + PtrW'(1);
      end
      if (disp_fire) begin
        state_q[disp_q] <= StExec;
        disp_q          <= disp_q + PtrW'(1);
      end
      pv_q[0]    <= disp_fire;
      pidx_q[0]  <= disp_q;
      pdata_q[0] <= sum_vec;
`ifdef ADDER_STATION_SATURATE_EN
      ppos_q[0]  <= pos_ovf;
      pneg_q[0]  <= neg_ovf;
`endif
      for (int s = 1; s < int'(LATENCY); s++) begin
        pv_q[s]    <= pv_q[s-1];
        pidx_q[s]  <= pidx_q[s-1];
        pdata_q[s] <= pdata_q[s-1];
`ifdef ADDER_STATION_SATURATE_EN
        ppos_q[s]  <= ppos_q[s-1];
        pneg_q[s]  <= pneg_q[s-1];
`endif
      end
      if (pv_q[LATENCY-1]) begin
        state_q[pidx_q[LATENCY-1]] <= StDone;
        res_q[pidx_q[LATENCY-1]]   <= wb_data;
      end
      if (commit_fire) begin
        state_q[cmt_q] <= StFree;
        cmt_q          <= cmt_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_adder_station_pipe.sv
// Scoreboard bench for adder_station_pipe: expected commits queued at issue, checked on grant.
module tb_adder_station_pipe;

  localparam int W = 32;
  localparam int LAT = 2;

  typedef struct {
    logic [7:0]  dst;
    logic [2:0]  we;
    logic [95:0] data;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  iId = 4'hA;
  logic        iIssueValid = 1'b0;
  logic        oIssueReady;
  logic        iIssueSub = 1'b0;
  logic [95:0] iIssueA = '0;
  logic [95:0] iIssueB = '0;
  logic [7:0]  iIssueDst = '0;
  logic [2:0]  iIssueWE = '0;
  logic        oCommitRequest;
  logic        iCommitGranted = 1'b0;
  logic [3:0]  oCommitId;
  logic [7:0]  oCommitDst;
  logic [2:0]  oCommitWE;
  logic [95:0] oCommitData;
  logic        oBusy;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  adder_station_pipe dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iId            (iId),
    .iIssueValid    (iIssueValid),
    .oIssueReady    (oIssueReady),
    .iIssueSub      (iIssueSub),
    .iIssueA        (iIssueA),
    .iIssueB        (iIssueB),
    .iIssueDst      (iIssueDst),
    .iIssueWE       (iIssueWE),
    .oCommitRequest (oCommitRequest),
    .iCommitGranted (iCommitGranted),
    .oCommitId      (oCommitId),
    .oCommitDst     (oCommitDst),
    .oCommitWE      (oCommitWE),
    .oCommitData    (oCommitData),
    .oBusy          (oBusy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W-1:0] lane_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub);
    logic signed [W:0] ext;
    ext = sub ? $signed({a[W-1], a}) - $signed({b[W-1], b})
              : $signed({a[W-1], a}) + $signed({b[W-1], b});
`ifdef ADDER_STATION_SATURATE_EN
    if (ext[W] != ext[W-1]) return ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return ext[W-1:0];
  endfunction

  function automatic logic [95:0] model_vec(input logic [95:0] a, input logic [95:0] b,
                                            input logic sub);
    logic [95:0] r;
    for (int l = 0; l < 3; l++) r[l*W +: W] = lane_model(a[l*W +: W], b[l*W +: W], sub);
    return r;
  endfunction

  // Commit monitor: a commit happens at the next edge when request and grant are both high.
  always @(negedge Clock) begin
    if (!Reset && oCommitRequest === 1'b1 && iCommitGranted === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: got dst=%0d data=%h, none expected", oCommitDst,
                 oCommitData);
      end else begin
        mon_e = sb.pop_front();
        if (oCommitDst !== mon_e.dst || oCommitWE !== mon_e.we || oCommitData !== mon_e.data ||
            oCommitId !== 4'hA) begin
          fails++;
          $display("FAIL commit_data: got id=%h dst=%0d we=%b data=%h, want id=a dst=%0d we=%b data=%h",
                   oCommitId, oCommitDst, oCommitWE, oCommitData, mon_e.dst, mon_e.we,
                   mon_e.data);
        end
      end
    end
  end

  task automatic issue_op(input logic sub, input logic [95:0] a, input logic [95:0] b,
                          input logic [7:0] dst, input logic [2:0] we);
    exp_t e;
    int n;
    iIssueValid = 1'b1;
    iIssueSub = sub;
    iIssueA = a;
    iIssueB = b;
    iIssueDst = dst;
    iIssueWE = we;
    e.dst = dst;
    e.we = we;
    e.data = model_vec(a, b, sub);
    n = 0;
    @(negedge Clock);
    while (oIssueReady !== 1'b1 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    tests++;
    if (oIssueReady !== 1'b1) begin
      fails++;
      $display("FAIL issue_timeout: ready=%b after %0d cycles, want 1", oIssueReady, n);
    end else begin
      sb.push_back(e);
    end
    @(posedge Clock);
    #1 iIssueValid = 1'b0;
  endtask

  task automatic wait_request(input string name);
    int n;
    n = 0;
    @(negedge Clock);
    while (oCommitRequest !== 1'b1 && n < 30) begin
      @(negedge Clock);
      n++;
    end
    tests++;
    if (oCommitRequest !== 1'b1) begin
      fails++;
      $display("FAIL %s_req_timeout: request=%b, want 1", name, oCommitRequest);
    end
  endtask

  task automatic drain(input string name);
    int n;
    iCommitGranted = 1'b1;
    n = 0;
    @(negedge Clock);
    while ((sb.size() != 0 || oBusy !== 1'b0) && n < 60) begin
      @(negedge Clock);
      n++;
    end
    tests++;
    if (sb.size() != 0 || oBusy !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: pending=%0d busy=%b, want 0 and 0", name, sb.size(), oBusy);
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    sb.delete();
    @(negedge Clock);
    tests++;
    if (oIssueReady !== 1'b1 || oCommitRequest !== 1'b0 || oBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: ready=%b req=%b busy=%b, want 1 0 0", oIssueReady,
               oCommitRequest, oBusy);
    end
    tests++;
    if (oCommitDst !== 8'd0 || oCommitWE !== 3'd0 || oCommitData !== 96'd0) begin
      fails++;
      $display("FAIL reset_outputs: dst=%0d we=%b data=%h, want zeros", oCommitDst, oCommitWE,
               oCommitData);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_basic_add;
    int k;
    iCommitGranted = 1'b1;
    issue_op(1'b0, {32'd3, 32'd2, 32'd1}, {32'd30, 32'd20, 32'd10}, 8'd5, 3'b111);
    k = 0;
    while (k < 12) begin
      @(negedge Clock);
      k++;
      if (oCommitRequest === 1'b1) break;
    end
    tests++;
    if (k != LAT + 2) begin
      fails++;
      $display("FAIL basic_latency: request after %0d cycles, want %0d", k, LAT + 2);
    end
    tests++;
    if (oCommitData !== {32'd33, 32'd22, 32'd11} || oCommitDst !== 8'd5 || oCommitId !== 4'hA) begin
      fails++;
      $display("FAIL basic_result: data=%h dst=%0d id=%h, want 21/16/0b dst=5 id=a", oCommitData,
               oCommitDst, oCommitId);
    end
    @(posedge Clock);
    #1;
    @(negedge Clock);
    tests++;
    if (oBusy !== 1'b0 || oCommitRequest !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: busy=%b req=%b, want 0 0", oBusy, oCommitRequest);
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b0;
  endtask

  task automatic test_sub_wrap;
    logic [31:0] exp0, exp1;
    issue_op(1'b1, {32'd7, 32'd100, 32'd0}, {32'd9, 32'd40, 32'd1}, 8'd6, 3'b001);
    wait_request("sub");
    tests++;
    if (oCommitData[31:0] !== 32'hFFFFFFFF || oCommitData[63:32] !== 32'd60) begin
      fails++;
      $display("FAIL sub_lanes: lane0=%h lane1=%h, want ffffffff 0000003c", oCommitData[31:0],
               oCommitData[63:32]);
    end
    drain("sub");
`ifdef ADDER_STATION_SATURATE_EN
    exp0 = 32'h7FFFFFFF;
    exp1 = 32'h80000000;
`else
    exp0 = 32'h80000000;
    exp1 = 32'h7FFFFFFF;
`endif
    issue_op(1'b0, {32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF}, {32'd2, 32'h80000000, 32'd1}, 8'd7,
             3'b111);
    wait_request("edge");
    tests++;
    if (oCommitData[31:0] !== exp0 || oCommitData[63:32] !== exp1 || oCommitData[95:64] !== 32'd3)
    begin
      fails++;
      $display("FAIL overflow_lanes: got %h, want lanes %h %h 00000003", oCommitData, exp0, exp1);
    end
    drain("edge");
  endtask

  task automatic test_full;
    exp_t e;
    bit acc5;
    iCommitGranted = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iIssueValid = 1'b1;
      iIssueSub = i[0];
      iIssueA = {32'(i * 3), 32'(i * 2), 32'(100 + i)};
      iIssueB = {32'd1, 32'd2, 32'(i)};
      iIssueDst = 8'(20 + i);
      iIssueWE = 3'(i + 1);
      e.dst = iIssueDst;
      e.we = iIssueWE;
      e.data = model_vec(iIssueA, iIssueB, iIssueSub);
      @(negedge Clock);
      tests++;
      if (oIssueReady !== (i < 4)) begin
        fails++;
        $display("FAIL full_ready_%0d: ready=%b, want %b", i, oIssueReady, i < 4);
      end
      if (oIssueReady === 1'b1 && i < 4) sb.push_back(e);
      @(posedge Clock);
      #1;
    end
    repeat (6) @(negedge Clock);
    tests++;
    if (oIssueReady !== 1'b0 || oBusy !== 1'b1) begin
      fails++;
      $display("FAIL full_held: ready=%b busy=%b, want 0 1", oIssueReady, oBusy);
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b1;
    acc5 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      tests++;
      if (oCommitRequest !== 1'b1) begin
        fails++;
        $display("FAIL full_consec_%0d: req=%b, want 1", k, oCommitRequest);
      end
      if (k == 0) begin
        tests++;
        if (oIssueReady !== 1'b0) begin
          fails++;
          $display("FAIL full_grant_same_cycle: ready=%b, want 0", oIssueReady);
        end
      end
      if (!acc5 && oIssueReady === 1'b1) begin
        sb.push_back(e);
        acc5 = 1'b1;
      end
      @(posedge Clock);
      #1 if (acc5) iIssueValid = 1'b0;
    end
    tests++;
    if (acc5 !== 1'b1) begin
      fails++;
      $display("FAIL full_fifth_accept: accepted=%b, want 1", acc5);
    end
    iIssueValid = 1'b0;
    drain("full");
  endtask

  task automatic test_hold;
    iCommitGranted = 1'b0;
    issue_op(1'b0, {32'd5, 32'd6, 32'd7}, {32'd50, 32'd60, 32'd70}, 8'd40, 3'b101);
    issue_op(1'b1, {32'd9, 32'd9, 32'd9}, {32'd1, 32'd2, 32'd3}, 8'd41, 3'b010);
    wait_request("hold");
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (oCommitRequest !== 1'b1 || oCommitData !== sb[0].data || oCommitDst !== sb[0].dst ||
          oCommitWE !== sb[0].we) begin
        fails++;
        $display("FAIL hold_stable_%0d: req=%b dst=%0d we=%b data=%h, want 1 %0d %b %h", c,
                 oCommitRequest, oCommitDst, oCommitWE, oCommitData, sb[0].dst, sb[0].we,
                 sb[0].data);
      end
      @(negedge Clock);
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b1;
    @(posedge Clock);
    #1 iCommitGranted = 1'b0;
    @(negedge Clock);
    tests++;
    if (sb.size() != 1 || oCommitRequest !== 1'b1 || oCommitDst !== 8'd41) begin
      fails++;
      $display("FAIL hold_one_commit: pending=%0d req=%b dst=%0d, want 1 1 41", sb.size(),
               oCommitRequest, oCommitDst);
    end
    drain("hold");
  endtask

  task automatic test_simultaneous;
    exp_t e;
    iCommitGranted = 1'b0;
    for (int i = 0; i < 4; i++)
      issue_op(1'b0, {32'(i), 32'(i), 32'(i)}, {32'd1000, 32'd2000, 32'd3000}, 8'(60 + i), 3'b111);
    wait_request("simul");
    @(posedge Clock);
    #1;
    iIssueValid = 1'b1;
    iIssueSub = 1'b1;
    iIssueA = {32'd10, 32'd20, 32'd30};
    iIssueB = {32'd11, 32'd21, 32'd31};
    iIssueDst = 8'd70;
    iIssueWE = 3'b110;
    e.dst = 8'd70;
    e.we = 3'b110;
    e.data = model_vec(iIssueA, iIssueB, 1'b1);
    iCommitGranted = 1'b1;
    @(negedge Clock);
    tests++;
    if (oIssueReady !== 1'b0 || oCommitRequest !== 1'b1) begin
      fails++;
      $display("FAIL simul_reject: ready=%b req=%b, want 0 1", oIssueReady, oCommitRequest);
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b0;
    @(negedge Clock);
    tests++;
    if (oIssueReady !== 1'b1) begin
      fails++;
      $display("FAIL simul_count3: ready=%b, want 1", oIssueReady);
    end else begin
      sb.push_back(e);
    end
    @(posedge Clock);
    #1 iIssueValid = 1'b0;
    @(negedge Clock);
    tests++;
    if (oIssueReady !== 1'b0 || oBusy !== 1'b1) begin
      fails++;
      $display("FAIL simul_count4: ready=%b busy=%b, want 0 1", oIssueReady, oBusy);
    end
    drain("simul");
  endtask

  task automatic test_reset_mid;
    iCommitGranted = 1'b0;
    for (int i = 0; i < 3; i++)
      issue_op(1'b0, {32'd1, 32'd1, 32'(i)}, {32'd2, 32'd2, 32'd2}, 8'(80 + i), 3'b011);
    Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    sb.delete();
    @(negedge Clock);
    tests++;
    if (oCommitRequest !== 1'b0 || oBusy !== 1'b0 || oIssueReady !== 1'b1) begin
      fails++;
      $display("FAIL midreset_flags: req=%b busy=%b ready=%b, want 0 0 1", oCommitRequest, oBusy,
               oIssueReady);
    end
    iCommitGranted = 1'b1;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge Clock);
      tests++;
      if (oCommitRequest !== 1'b0) begin
        fails++;
        $display("FAIL midreset_stale_%0d: req=%b, want 0", c, oCommitRequest);
      end
    end
    @(posedge Clock);
    #1 iCommitGranted = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_sub_wrap;
    test_full;
    test_hold;
    test_simultaneous;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
